// File: rtl/vga_scan_param.sv
// vga_scan_param: parameterised VGA raster generator with a latency-matched
// pixel fetch path.
//
// A horizontal/vertical counter pair walks the raster in the order
// sync, back porch, active, front porch. From the counter value ("stage 0")
// the block issues a pixel read request (rd_en, row_addr, col_addr) one cycle
// later. The source answers RD_LAT cycles after the request. The sync, enable
// and marker signals travel down a shift pipeline, so every output belonging
// to one counter value appears together, RD_LAT+2 cycles after that value.
//
// Ports:
//   vga_clk      pixel clock
//   rst          asynchronous, active-high reset
//   en           scan enable; low clears and holds the counters at (0,0)
//   d_in         pixel from the source, {b,g,r} with r in the LSBs
//   rd_en        pixel read request
//   row_addr     requested row (0 when rd_en=0)
//   col_addr     requested column (0 when rd_en=0)
//   r, g, b      colour outputs, forced to 0 outside the display window
//   hs, vs       sync outputs, active level HS_POL / VS_POL
//   de           display enable
//   line_start   one-cycle pulse for hcnt=0
//   frame_start  one-cycle pulse for hcnt=0, vcnt=0
module vga_scan_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CDW      = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 1,
  localparam int RW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int CW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3*CDW-1:0] d_in,
  output logic             rd_en,
  output logic [RW-1:0]    row_addr,
  output logic [CW-1:0]    col_addr,
  output logic [CDW-1:0]   r,
  output logic [CDW-1:0]   g,
  output logic [CDW-1:0]   b,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Pipeline depth from counter value to outputs.
  localparam int PD      = RD_LAT + 2;

  // Window bounds kept at 32 bits so the compares never truncate.
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_SYN_HI = 32'(H_SYNC);
  localparam logic [31:0] V_SYN_HI = 32'(V_SYNC);
  localparam logic [31:0] H_ACT_LO = 32'(H_SYNC + H_BP);
  localparam logic [31:0] H_ACT_HI = 32'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [31:0] V_ACT_LO = 32'(V_SYNC + V_BP);
  localparam logic [31:0] V_ACT_HI = 32'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0]   h32;
  logic [31:0]   v32;
  logic          h_last;
  logic          v_last;

  assign h32    = 32'(hcnt);
  assign v32    = 32'(vcnt);
  assign h_last = (h32 == H_LAST);
  assign v_last = (v32 == V_LAST);

  // Raster counters. en=0 parks them at (0,0) so the first enabled edge
  // samples the frame origin.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Stage 0: decode of the current counter value. Everything is qualified by
  // en so that disabled cycles enter the pipeline as blank, inactive entries.
  logic          act0;
  logic          hs0;
  logic          vs0;
  logic          ls0;
  logic          fs0;
  logic [CW-1:0] col0;
  logic [RW-1:0] row0;

  always_comb begin
    act0 = en && (h32 >= H_ACT_LO) && (h32 < H_ACT_HI)
              && (v32 >= V_ACT_LO) && (v32 < V_ACT_HI);
    hs0  = (en && (h32 < H_SYN_HI)) ? HS_POL : ~HS_POL;
    vs0  = (en && (v32 < V_SYN_HI)) ? VS_POL : ~VS_POL;
    ls0  = en && (hcnt == '0);
    fs0  = en && (hcnt == '0) && (vcnt == '0);
    col0 = '0;
    row0 = '0;
    if (act0) begin
      col0 = CW'(hcnt - HW'(H_SYNC + H_BP));
      row0 = RW'(vcnt - VW'(V_SYNC + V_BP));
    end
  end

  // Read request, one cycle after the counter value.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      rd_en    <= 1'b0;
      row_addr <= '0;
      col_addr <= '0;
    end else begin
      rd_en    <= act0;
      row_addr <= row0;
      col_addr <= col0;
    end
  end

  // Control shift pipeline. Entry k holds the stage-0 decode from k+1 edges
  // ago; the last entry drives the outputs. It keeps shifting while en=0 so
  // entries already in flight still reach the outputs.
  logic [PD-1:0] hs_p;
  logic [PD-1:0] vs_p;
  logic [PD-1:0] de_p;
  logic [PD-1:0] ls_p;
  logic [PD-1:0] fs_p;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hs_p <= {PD{~HS_POL}};
      vs_p <= {PD{~VS_POL}};
      de_p <= '0;
      ls_p <= '0;
      fs_p <= '0;
    end else begin
      hs_p <= {hs_p[PD-2:0], hs0};
      vs_p <= {vs_p[PD-2:0], vs0};
      de_p <= {de_p[PD-2:0], act0};
      ls_p <= {ls_p[PD-2:0], ls0};
      fs_p <= {fs_p[PD-2:0], fs0};
    end
  end

  assign hs          = hs_p[PD-1];
  assign vs          = vs_p[PD-1];
  assign de          = de_p[PD-1];
  assign line_start  = ls_p[PD-1];
  assign frame_start = fs_p[PD-1];

  // Colour capture. The source answer for a request made on edge E is on
  // d_in during the cycle before edge E+RD_LAT+1; that edge is also where
  // the matching de reaches the output stage, so de_p[RD_LAT] is the mask.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (de_p[RD_LAT]) begin
      r <= d_in[CDW-1:0];
      g <= d_in[2*CDW-1:CDW];
      b <= d_in[3*CDW-1:2*CDW];
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
    end
  end

endmodule
